ov7670_cfg_sequencer: RTL and testbench

Walks the OV7670 configuration ROM from address 0 and turns each 16-bit entry {reg[15:8], data[7:0]} into one write command for the SCCB master, using a valid/ready handshake. Entry 16'hFF_F0 inserts a settling delay. Entry 16'hFF_FF ends the sequence. The block sits between the config ROM, which is read registered with 1-cycle latency, and the SCCB bit-level master. It reports busy and done to the top-level camera controller.

---
 rtl/ov7670_cfg_sequencer_pkg.sv | 25 ++
 rtl/ov7670_cfg_sequencer_if.sv | 12 +
 rtl/ov7670_cfg_sequencer_delay_timer.sv | 28 ++
 rtl/ov7670_cfg_sequencer.sv | 124 ++++++++++++
 tb/tb_ov7670_cfg_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ov7670_cfg_sequencer_pkg.sv
// Shared constants and types for the OV7670 configuration sequencer.
// Covers ROM marker words, the sequencer state set and ROM entry field positions.
package ov7670_cfg_pkg;

   localparam logic [15:0] CFG_END_WORD         = 16'hFFFF;
   localparam logic [15:0] CFG_DELAY_WORD       = 16'hFFF0;
   localparam int          DEFAULT_DELAY_CYCLES = 250000;

   // ROM entry layout: {register address, register value}
   localparam int ENTRY_REG_MSB  = 15;
   localparam int ENTRY_REG_LSB  = 8;
   localparam int ENTRY_DATA_MSB = 7;
   localparam int ENTRY_DATA_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ROMWAIT,
      ST_DECODE,
      ST_SEND,
      ST_DELAY,
      ST_DONE
   } cfg_state_e;

endpackage

// File: rtl/ov7670_cfg_sequencer_if.sv
// Write-command channel from the configuration sequencer to the SCCB master.
// Handshake: a transfer happens on a clock edge where cmd_valid and cmd_ready are both 1; once raised,
// cmd_valid, cmd_reg and cmd_data stay stable until that edge, and cmd_valid never depends on cmd_ready.
interface ov7670_cfg_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_reg;
   logic [7:0] cmd_data;

   modport master (output cmd_valid, output cmd_reg, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_reg, input cmd_data, output cmd_ready);
endinterface

// File: rtl/ov7670_cfg_sequencer_delay_timer.sv
// Loadable down-counter. expired is high while the count sits at zero.
// Also usable for the post-reset camera power-up wait.
module cfg_delay_timer #(
   parameter int W = 18
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// Walks the OV7670 configuration ROM and issues one SCCB write per entry.
// Marker entries insert a settling delay or end the sequence.
module ov7670_cfg_sequencer
   import ov7670_cfg_pkg::*;
#(
   parameter int          ADDR_W       = 8,
   parameter int          DELAY_CYCLES = DEFAULT_DELAY_CYCLES,
   parameter logic [15:0] END_WORD     = CFG_END_WORD,
   parameter logic [15:0] DELAY_WORD   = CFG_DELAY_WORD
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   output logic [ADDR_W-1:0]          rom_addr,
   input  logic [15:0]                rom_data,
   ov7670_cfg_sequencer_if.master     cmd,
   output logic                       busy,
   output logic                       done,
   output logic [7:0]                 write_count,
   output cfg_state_e                 dbg_state
);

   // The counter holds DELAY_CYCLES-1 down to 0, so DELAY_CYCLES values in total.
   localparam int                CNT_W    = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  DLY_LOAD = CNT_W'(DELAY_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   cfg_state_e  state;
   logic [15:0] entry;
   logic        dly_load;
   logic        dly_en;
   logic        dly_expired;
   logic        last_addr;

   assign dly_load  = (state == ST_DECODE) && (entry == DELAY_WORD);
   assign dly_en    = (state == ST_DELAY);
   assign last_addr = (rom_addr == ADDR_MAX);
   assign dbg_state = state;

   cfg_delay_timer #(
      .W (CNT_W)
   ) u_delay (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (dly_load),
      .load_val (DLY_LOAD),
      .en       (dly_en),
      .expired  (dly_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         rom_addr      <= '0;
         entry         <= '0;
         cmd.cmd_valid <= 1'b0;
         cmd.cmd_reg   <= '0;
         cmd.cmd_data  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         write_count   <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state       <= ST_ADDR;
                  rom_addr    <= '0;
                  write_count <= '0;
                  busy        <= 1'b1;
                  done        <= 1'b0;
               end
            end
            ST_ADDR: state <= ST_ROMWAIT;
            ST_ROMWAIT: begin
               entry <= rom_data;
               state <= ST_DECODE;
            end
            ST_DECODE: begin
               if (entry == END_WORD) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (entry == DELAY_WORD) begin
                  state <= ST_DELAY;
               end else begin
                  state         <= ST_SEND;
                  cmd.cmd_valid <= 1'b1;
                  cmd.cmd_reg   <= entry[ENTRY_REG_MSB:ENTRY_REG_LSB];
                  cmd.cmd_data  <= entry[ENTRY_DATA_MSB:ENTRY_DATA_LSB];
               end
            end
            ST_SEND: begin
               if (cmd.cmd_ready) begin
                  cmd.cmd_valid <= 1'b0;
                  if (write_count != 8'hFF) write_count <= write_count + 8'd1;
                  // The top address is terminal: finish instead of wrapping to 0.
                  if (last_addr) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     rom_addr <= rom_addr + 1'b1;
                     state    <= ST_ADDR;
                  end
               end
            end
            ST_DELAY: begin
               if (dly_expired) begin
                  if (last_addr) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     rom_addr <= rom_addr + 1'b1;
                     state    <= ST_ADDR;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Self-checking bench for ov7670_cfg_sequencer: reference ROM walk model feeds an expected queue,
// a monitor checks every presented command, its timing and the sequencer status outputs.
module tb_ov7670_cfg_sequencer;
   import ov7670_cfg_pkg::*;

   localparam int DLY = 20;
   localparam int AW  = 8;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [AW-1:0] rom_addr;
   logic [15:0] rom_data;
   logic        busy;
   logic        done;
   logic [7:0]  write_count;
   cfg_state_e  dbg_state;

   ov7670_cfg_sequencer_if cmd_if ();

   logic [15:0] rom [256];
   int          cyc = 0;
   int          chk_total = 0;
   int          chk_err = 0;
   logic [15:0] exp_q[$];
   int          gap_q[$];
   int          exp_final_addr;
   int          exp_final_wc;
   int          ready_mode = 0;
   int          run_id = 0;

   ov7670_cfg_sequencer #(
      .ADDR_W       (AW),
      .DELAY_CYCLES (DLY)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .cmd         (cmd_if),
      .busy        (busy),
      .done        (done),
      .write_count (write_count),
      .dbg_state   (dbg_state)
   );

   // clock, cycle counter and registered ROM model
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rom_data <= rom[rom_addr];
   end

   task automatic check(input string name, input longint act, input longint exp);
      chk_total++;
      if (act !== exp) begin
         chk_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      chk_total++;
      chk_err++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // cmd_ready driver: 0 = always ready, 1 = random, 2 = 7 stall cycles on the first command
   int hold_cnt = 0;
   int drv_run  = -1;
   always @(posedge clk) begin
      #1;
      if (drv_run != run_id) begin
         drv_run  = run_id;
         hold_cnt = 0;
      end
      case (ready_mode)
         0: cmd_if.cmd_ready = 1'b1;
         1: cmd_if.cmd_ready = ($urandom_range(0, 2) != 0);
         default: begin
            if (cmd_if.cmd_valid && hold_cnt < 7) begin
               cmd_if.cmd_ready = 1'b0;
               hold_cnt++;
            end else begin
               cmd_if.cmd_ready = 1'b1;
            end
         end
      endcase
   end

   // monitor: compares presented commands with the expected queue
   int   mon_run = -1;
   int   acc_cnt = 0;
   int   rises = 0;
   int   stall_cycles = 0;
   bit   have_acc = 0;
   int   last_acc = 0;
   logic prev_valid = 1'b0;
   logic prev_stall = 1'b0;

   always @(negedge clk) begin
      if (mon_run != run_id) begin
         mon_run      = run_id;
         acc_cnt      = 0;
         rises        = 0;
         stall_cycles = 0;
         have_acc     = 0;
         prev_valid   = 1'b0;
         prev_stall   = 1'b0;
      end
      if (rst_n) begin
         if (cmd_if.cmd_valid && !prev_valid) begin
            rises++;
            if (have_acc) begin
               if (gap_q.size() == 0) fail("gap_queue_empty");
               else check("valid_gap", cyc - last_acc, gap_q.pop_front());
            end
         end
         if (prev_stall) check("valid_held", cmd_if.cmd_valid, 1);
         if (cmd_if.cmd_valid) begin
            check("busy_while_valid", busy, 1);
            if (exp_q.size() == 0) begin
               fail("unexpected_cmd");
            end else begin
               check("cmd_word", {cmd_if.cmd_reg, cmd_if.cmd_data}, exp_q[0]);
               if (cmd_if.cmd_ready) begin
                  check("write_count_at_accept", write_count, (acc_cnt > 255) ? 255 : acc_cnt);
                  void'(exp_q.pop_front());
                  acc_cnt++;
                  have_acc = 1;
                  last_acc = cyc;
               end else begin
                  stall_cycles++;
               end
            end
         end
         prev_valid = cmd_if.cmd_valid;
         prev_stall = cmd_if.cmd_valid && !cmd_if.cmd_ready;
      end else begin
         prev_valid = 1'b0;
         prev_stall = 1'b0;
      end
   end

   // reference model: walk the ROM image by the sequencer's rules
   task automatic build_expect();
      int d = 0;
      int n = 0;
      exp_q.delete();
      gap_q.delete();
      exp_final_addr = 255;
      for (int a = 0; a < 256; a++) begin
         if (rom[a] == 16'hFFFF) begin
            exp_final_addr = a;
            break;
         end else if (rom[a] == 16'hFFF0) begin
            d++;
         end else begin
            exp_q.push_back(rom[a]);
            if (n > 0) gap_q.push_back(4 + d * (DLY + 3));
            d = 0;
            n++;
         end
      end
      exp_final_wc = (n > 255) ? 255 : n;
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("start_rom_addr", rom_addr, 0);
      check("start_write_count", write_count, 0);
      check("start_busy", busy, 1);
      check("start_done", done, 0);
   endtask

   task automatic run_seq(input int mode, input bit mid_start);
      int  t = 0;
      bit  pulsed = 0;
      ready_mode = mode;
      build_expect();
      run_id++;
      pulse_start();
      while (!done && t < 20000) begin
         @(negedge clk);
         t++;
         if (mid_start) begin
            if (start) start = 1'b0;
            else if (!pulsed && rises == 3) begin
               start  = 1'b1;
               pulsed = 1;
            end
         end
      end
      start = 1'b0;
      if (!done) fail("done_timeout");
      check("end_busy", busy, 0);
      check("end_write_count", write_count, exp_final_wc);
      check("end_rom_addr", rom_addr, exp_final_addr);
      check("end_cmds_outstanding", exp_q.size(), 0);
      check("end_state", dbg_state, ST_DONE);
      repeat (3) @(negedge clk);
      check("done_sticky", done, 1);
      check("valid_idle_after_done", cmd_if.cmd_valid, 0);
   endtask

   task automatic fill_rom(input logic [15:0] w);
      for (int a = 0; a < 256; a++) rom[a] = w;
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      int t;
      int len;
      fill_rom(16'hFFFF);
      repeat (3) @(negedge clk);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_write_count", write_count, 0);
      check("rst_cmd_valid", cmd_if.cmd_valid, 0);
      check("rst_state", dbg_state, ST_IDLE);
      @(negedge clk);
      rst_n = 1'b1;

      // two writes then end
      rom[0] = 16'h1280; rom[1] = 16'h1185; rom[2] = 16'hFFFF;
      run_seq(0, 0);

      // delay marker between writes
      rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1200; rom[3] = 16'hFFFF;
      run_seq(0, 0);

      // first command stalled for 7 cycles
      rom[0] = 16'h1280; rom[1] = 16'h1185; rom[2] = 16'hFFFF;
      run_seq(2, 0);
      check("stall_cycles", stall_cycles, 7);

      // no end marker: runs to the top address and stops
      fill_rom(16'h0101);
      run_seq(1, 0);

      // start during the third command is ignored, then start after done repeats
      fill_rom(16'hFFFF);
      for (int a = 0; a < 5; a++) rom[a] = 16'($urandom_range(0, 16'hFFEF));
      run_seq(0, 1);
      run_seq(1, 0);

      // random ROM images with occasional delay markers
      for (int it = 0; it < 4; it++) begin
         fill_rom(16'hFFFF);
         len = $urandom_range(3, 12);
         for (int a = 0; a < len; a++) begin
            if ($urandom_range(0, 7) == 0) rom[a] = 16'hFFF0;
            else rom[a] = 16'($urandom_range(0, 16'hFFEF));
         end
         run_seq(1, 0);
      end

      // reset asserted while waiting in a delay
      fill_rom(16'hFFFF);
      rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1200; rom[3] = 16'hFFFF;
      ready_mode = 0;
      build_expect();
      run_id++;
      pulse_start();
      t = 0;
      while (acc_cnt < 1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (acc_cnt < 1) fail("first_accept_timeout");
      repeat (8) @(negedge clk);
      check("in_delay_before_reset", dbg_state, ST_DELAY);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_cmd_valid", cmd_if.cmd_valid, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
      check("async_rst_write_count", write_count, 0);
      check("async_rst_state", dbg_state, ST_IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      gap_q.delete();
      run_seq(0, 0);

      $display("Result: errors=%0d of %0d checks", chk_err, chk_total);
      $finish;
   end

endmodule
